// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: decodes IR, sequences FETCH/DECODE/EXEC/MEM/WB/HALT, drives datapath strobes.
// Optional: define CU_FAST_BRANCH_EN to resolve BEQ/BNE/J/JR in DECODE.
module multicycle_control_unit #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] instruction,
    input  logic        equal,
    input  logic        ihit,
    input  logic        dhit,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        IRWr,
    output logic        PCWr,
    output logic        RegWr,
    output logic [1:0]  PCSrc,
    output logic [1:0]  ALUSrc,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  reg_dest,
    output logic [3:0]  alu_op,
    output logic        extend,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] imm16,
    output logic [25:0] addr,
    output logic [2:0]  state,
    output logic        halt
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE,
        C_J, C_JR, C_JAL, C_HALT, C_BAD
    } iclass_t;

    localparam logic [1:0] PC_NEXT = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_REG = 2'd3;
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                           ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
    localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    iclass_t           cls_s;
    logic              redirect_s;
    logic [1:0]        redirect_src_s;
    logic              iren_s, dren_s, dwen_s, irwr_s, pcwr_s, regwr_s;
    logic [5:0]        opcode_s, funct_s;

    assign opcode_s = instruction[31:26];
    assign funct_s  = instruction[5:0];
    assign Rs       = instruction[25:21];
    assign Rt       = instruction[20:16];
    assign Rd       = instruction[15:11];
    assign imm16    = instruction[15:0];
    assign addr     = instruction[25:0];

    // Instruction decode: class, ALU control, extension and writeback selects
    always_comb begin
        cls_s      = C_BAD;
        alu_op     = ALU_ADD;
        ALUSrc     = 2'd0;
        extend     = 1'b1;
        reg_dest   = 2'd0;
        mem_to_reg = 2'd0;
        case (opcode_s)
            6'b000000: begin
                cls_s = C_RALU;
                case (funct_s)
                    6'b000000: alu_op = ALU_SLL;
                    6'b000010: alu_op = ALU_SRL;
                    6'b001000: cls_s  = C_JR;
                    6'b100000, 6'b100001: alu_op = ALU_ADD;
                    6'b100010, 6'b100011: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b100110: alu_op = ALU_XOR;
                    6'b100111: alu_op = ALU_NOR;
                    6'b101010: alu_op = ALU_SLT;
                    6'b101011: alu_op = ALU_SLTU;
                    default:   cls_s  = C_BAD;
                endcase
            end
            6'b000010: cls_s = C_J;
            6'b000011: begin cls_s = C_JAL; reg_dest = 2'd2; mem_to_reg = 2'd2; end
            6'b000100: begin cls_s = C_BEQ; alu_op = ALU_SUB; end
            6'b000101: begin cls_s = C_BNE; alu_op = ALU_SUB; end
            6'b001000, 6'b001001: begin cls_s = C_IALU; ALUSrc = 2'd1; reg_dest = 2'd1; end
            6'b001010: begin cls_s = C_IALU; ALUSrc = 2'd1; reg_dest = 2'd1; alu_op = ALU_SLT; end
            6'b001011: begin cls_s = C_IALU; ALUSrc = 2'd1; reg_dest = 2'd1; alu_op = ALU_SLTU; end
            6'b001100: begin cls_s = C_IALU; ALUSrc = 2'd1; reg_dest = 2'd1; alu_op = ALU_AND; extend = 1'b0; end
            6'b001101: begin cls_s = C_IALU; ALUSrc = 2'd1; reg_dest = 2'd1; alu_op = ALU_OR;  extend = 1'b0; end
            6'b001110: begin cls_s = C_IALU; ALUSrc = 2'd1; reg_dest = 2'd1; alu_op = ALU_XOR; extend = 1'b0; end
            // LUI: the datapath presents imm16<<16 on ALUSrc=2 and ORs it with zero
            6'b001111: begin cls_s = C_IALU; ALUSrc = 2'd2; reg_dest = 2'd1; alu_op = ALU_OR;  extend = 1'b0; end
            6'b100011: begin cls_s = C_LW; ALUSrc = 2'd1; reg_dest = 2'd1; mem_to_reg = 2'd1; end
            6'b101011: begin cls_s = C_SW; ALUSrc = 2'd1; end
            6'b111111: cls_s = C_HALT;
            default:   cls_s = C_BAD;
        endcase
    end

    // PC redirect decision for control-flow instructions
    always_comb begin
        redirect_s     = 1'b0;
        redirect_src_s = PC_NEXT;
        case (cls_s)
            C_BEQ:        begin redirect_s = equal;  redirect_src_s = PC_BRANCH; end
            C_BNE:        begin redirect_s = !equal; redirect_src_s = PC_BRANCH; end
            C_J, C_JAL:   begin redirect_s = 1'b1;   redirect_src_s = PC_JUMP;   end
            C_JR:         begin redirect_s = 1'b1;   redirect_src_s = PC_REG;    end
            default:      begin redirect_s = 1'b0;   redirect_src_s = PC_NEXT;   end
        endcase
    end

    // State and EXEC counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iren_s  = 1'b0;
        dren_s  = 1'b0;
        dwen_s  = 1'b0;
        irwr_s  = 1'b0;
        pcwr_s  = 1'b0;
        regwr_s = 1'b0;
        PCSrc   = PC_NEXT;
        case (state_q)
            S_FETCH: begin
                iren_s = 1'b1;
                if (ihit) begin
                    irwr_s  = 1'b1;
                    pcwr_s  = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (cls_s == C_HALT) begin
                    state_d = S_HALT;
                end
`ifdef CU_FAST_BRANCH_EN
                else if (cls_s == C_BEQ || cls_s == C_BNE || cls_s == C_J || cls_s == C_JR) begin
                    pcwr_s  = redirect_s;
                    PCSrc   = redirect_src_s;
                    state_d = S_FETCH;
                end
`endif
                else begin
                    state_d = S_EXEC;
                    cnt_d   = EXEC_LOAD;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    case (cls_s)
                        C_RALU, C_IALU: state_d = S_WB;
                        C_LW, C_SW:     state_d = S_MEM;
                        C_BEQ, C_BNE, C_J, C_JR: begin
                            pcwr_s  = redirect_s;
                            PCSrc   = redirect_src_s;
                            state_d = S_FETCH;
                        end
                        C_JAL: begin
                            pcwr_s  = 1'b1;
                            PCSrc   = PC_JUMP;
                            state_d = S_WB;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_MEM: begin
                if (cls_s == C_LW) begin
                    dren_s  = 1'b1;
                    state_d = dhit ? S_WB : S_MEM;
                end else if (cls_s == C_SW) begin
                    dwen_s  = 1'b1;
                    state_d = dhit ? S_FETCH : S_MEM;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                regwr_s = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are forced low combinationally while reset is held
    assign iREN  = iren_s  & nRST;
    assign dREN  = dren_s  & nRST;
    assign dWEN  = dwen_s  & nRST;
    assign IRWr  = irwr_s  & nRST;
    assign PCWr  = pcwr_s  & nRST;
    assign RegWr = regwr_s & nRST;
    assign state = state_q;
    assign halt  = (state_q == S_HALT);
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised FSM control unit for the multicycle MIPS datapath; successor to the single-cycle decoder. Decodes the instruction register, sequences FETCH/DECODE/EXEC/MEM/WB, and drives datapath mux selects and register/PC/IR write strobes. Memory requests are held until the `ihit`/`dhit` handshake from the memory controller. The execute phase has a configurable length.

## Interface
Parameters:
- `EXEC_CYCLES`, default 1: cycles spent in EXEC (1–15); covers multi-cycle ALU paths.
- `CNT_W`, default 4: width of the EXEC counter; requires `EXEC_CYCLES < 2**CNT_W`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `CLK` in 1: clock.
  - `nRST` in 1: asynchronous, active-low reset.
- Inputs:
  - `instruction` in 32 (`word_t`): IR contents.
  - `equal` in 1: ALU zero flag.
  - `ihit` in 1: instruction fetch complete.
  - `dhit` in 1: data access complete.
- Memory and write-strobe outputs:
  - `iREN` out 1: instruction read request.
  - `dREN` out 1: data read request.
  - `dWEN` out 1: data write request.
  - `IRWr` out 1: IR load.
  - `PCWr` out 1: PC load.
  - `RegWr` out 1: register file write.
- Mux-select outputs:
  - `PCSrc` out `pc_mux_input_selection`.
  - `ALUSrc` out `alu_source_mux_selection`.
  - `mem_to_reg` out `mem_to_reg_mux_selection`.
  - `reg_dest` out `reg_dest_mux_selection`.
  - `alu_op` out `aluop_t`.
- Decoded fields and status outputs:
  - `extend` out 1: sign (1) / zero (0) extension of `imm16`.
  - `Rs`, `Rt`, `Rd` out 5 each (`regbits_t`): decoded register fields.
  - `imm16` out 16: immediate field.
  - `addr` out 26: jump target field.
  - `state` out 3: current state, for debug and bench.
  - `halt` out 1: sticky halt.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Moore outputs derive from state plus the decoded opcode/funct.
- FETCH:
  - `iREN`=1 until `ihit`.
  - On the `ihit` cycle: `IRWr`=1, `PCWr`=1, `PCSrc`=PC+4, next state DECODE.
- DECODE:
  - One cycle. Fields `Rs/Rt/Rd/imm16/addr` are combinational from `instruction` in all states.
  - `extend`=0 for ANDI/ORI/XORI/LUI, 1 otherwise.
  - HALT opcode goes to HALT. All other instructions go to EXEC.
- EXEC:
  - Counter loads `EXEC_CYCLES-1` on entry, decrements each cycle, and the state exits when it reads 0.
  - `alu_op`/`ALUSrc` are valid throughout EXEC.
- Exit from EXEC, by instruction:
  - R-type ALU and I-type ALU: WB.
  - LW, SW: MEM.
  - BEQ/BNE: `PCWr`=(`equal` for BEQ, !`equal` for BNE), `PCSrc`=branch; then FETCH.
  - J: `PCWr`=1, `PCSrc`=jump; then FETCH.
  - JR: `PCWr`=1, `PCSrc`=register; then FETCH.
  - JAL: `PCWr`=1, `PCSrc`=jump; then WB.
  - Unknown opcode: no strobes; FETCH.
- MEM:
  - LW holds `dREN`=1 until `dhit`, then goes to WB.
  - SW holds `dWEN`=1 until `dhit`, then goes to FETCH.
  - `ihit` is ignored in MEM.
- WB:
  - `RegWr`=1 for one cycle, then FETCH.
  - `reg_dest`: rd (R-type), rt (I-type/LW), r31 (JAL).
  - `mem_to_reg`: memory (LW), PC+4 (JAL), ALU (others).
- HALT: absorbing. `halt`=1, all strobes 0 until `nRST`.
- Strobes (`iREN`, `dREN`, `dWEN`, `IRWr`, `PCWr`, `RegWr`) are mutually exclusive per cycle, except `IRWr`+`PCWr` together in FETCH.

## Timing
- Reset (`nRST`=0, any cycle, including mid-MEM):
  - State goes to FETCH immediately and the counter clears.
  - All strobes read 0 while `nRST`=0. `iREN` is gated by `nRST`.
  - `halt`=0.
- First `iREN`=1 is in the first cycle after `nRST` rises.
- Latency with zero-wait memory (hit in the same cycle as the request, `EXEC_CYCLES`=1):
  - ALU instructions: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/J/JR: 3 cycles.
  - JAL: 4 cycles.
- Each added `EXEC_CYCLES` adds 1 cycle. Each memory wait cycle adds 1 cycle.
- `ihit`/`dhit` are sampled only in the state that requested them. Stray hits elsewhere are ignored.
- A request stays asserted, and its data is unchanged, until the hit.

## Configuration
- `CU_FAST_BRANCH_EN` defined:
  - BEQ/BNE/J/JR resolve in DECODE (`PCWr`/`PCSrc` as above), skipping EXEC. They take 2 cycles at zero wait.
  - JAL is unchanged.
- Undefined: branches and jumps resolve at the end of EXEC as described above.

## Test plan
- Reset then release with `ihit` held 1:
  - `iREN`=1 in cycle 1.
  - `state` sequence 0→1→2→4→0 for ADDU; `RegWr`=1 only in cycle 4.
- LW with `dhit` delayed 3 cycles: `dREN` held 4 cycles, `RegWr` pulses once, `mem_to_reg`=memory.
- BEQ, `equal`=1 vs 0:
  - `PCWr`=1 with `PCSrc`=branch, or `PCWr`=0.
  - Next state FETCH; 3 cycles, or 2 with `CU_FAST_BRANCH_EN`.
- `EXEC_CYCLES`=3, ORI: EXEC lasts exactly 3 cycles, `extend`=0, `reg_dest`=rt.
- HALT opcode: `halt`=1 and sticky; no strobes for 20 cycles; `nRST` pulse returns to FETCH with `halt`=0.
- Reset asserted mid-MEM during SW: `dWEN` drops in the same cycle; after release, FETCH with `iREN`=1.
